seven_segment_scanner: RTL and testbench

Time-multiplexed display controller that drives a common-anode, N-digit seven-segment bank through a single shared `seven_segment` hex decoder. It double-buffers a packed hex word from the host and scans digits one at a time with a programmable dwell and an anti-ghosting blank gap. Optional leading-zero suppression is supported. It sits between the lab datapath's result registers and the board's segment/anode pins.

---
 rtl/seg_defs_pkg.sv | 12 +
 rtl/seven_segment.sv | 30 +++
 rtl/seven_segment_scanner.sv | 136 +++++++++++++
 tb/tb_seven_segment_scanner.sv | 138 +++++++++++++
 4 files changed

// File: rtl/seg_defs_pkg.sv
// rtl/seg_defs_pkg.sv - shared constants and state encoding for the segment scanner
package seg_defs;

  // Segment vectors are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seven_segment.sv
// rtl/seven_segment.sv - hex nibble to active-low {g..a} segment decoder
module seven_segment (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - double-buffered, time-multiplexed common-anode display scanner
module seven_segment_scanner
  import seg_defs::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  lz_suppress,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  scan_state_t          r_state;
  scan_state_t          w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_next;
  logic                 w_slot_end;
  logic                 w_frame_wrap;

  logic [4*DIGITS-1:0]  r_shadow;
  logic                 r_pending;
  logic [4*DIGITS-1:0]  r_active;

  logic [3:0]           w_nibble;
  logic [6:0]           w_dec_seg;
  logic                 w_upper_zero;
  logic                 w_suppress;

  logic [6:0]           r_seg;
  logic [DIGITS-1:0]    r_an;
  logic                 r_frame_done;

  assign w_slot_end   = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_frame_wrap = w_slot_end && (r_idx == IDX_W'(DIGITS - 1));
  assign w_cnt_next   = w_slot_end ? '0 : r_cnt + CNT_W'(1);

  always_comb begin
    w_idx_next = r_idx;
    if (w_slot_end) begin
      w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BLANK: if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) w_state_next = ST_SHOW;
      ST_SHOW:  if (w_slot_end) w_state_next = ST_BLANK;
      default:  w_state_next = ST_BLANK;
    endcase
  end

  // The frame_done cycle is the swap point: a load there bypasses the shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_active  <= '0;
    end else if (r_frame_done) begin
      if (load) begin
        r_active <= data_in;
      end else if (r_pending) begin
        r_active <= r_shadow;
      end
      r_pending <= 1'b0;
    end else if (load) begin
      r_shadow  <= data_in;
      r_pending <= 1'b1;
    end
  end

  always_comb begin
    w_nibble     = r_active[4*w_idx_next +: 4];
    w_upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(w_idx_next) && r_active[4*k +: 4] != 4'h0) begin
        w_upper_zero = 1'b0;
      end
    end
  end

  assign w_suppress = lz_suppress && (w_idx_next != '0) && w_upper_zero;

  seven_segment u_decoder (
    .i_hex (w_nibble),
    .o_seg (w_dec_seg)
  );

  // Pattern and anode are latched together on SHOW entry and held for the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= SEG_BLANK;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_wrap;
      if (w_state_next == ST_SHOW) begin
        if (r_state == ST_BLANK) begin
          r_an  <= ~(DIGITS'(1) << w_idx_next);
          r_seg <= w_suppress ? SEG_BLANK : w_dec_seg;
        end
      end else begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
      end
    end
  end

  assign seg_out    = r_seg;
  assign an_out     = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - directed self-checking bench for seven_segment_scanner
module tb_seven_segment_scanner;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic        lz_suppress;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int n_total;
  int n_pass;

  seven_segment_scanner #(
    .DIGITS       (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .data_in     (data_in),
    .lz_suppress (lz_suppress),
    .seg_out     (seg_out),
    .an_out      (an_out),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at the sampling point of slot offset 0; leaves at offset 0 of the next slot.
  task automatic check_slot(input int d, input logic [6:0] seg, input logic fd,
                            input int ld_off, input logic [15:0] ld_val);
    logic [3:0] an_exp;
    case (d)
      0:       an_exp = 4'b1110;
      1:       an_exp = 4'b1101;
      2:       an_exp = 4'b1011;
      default: an_exp = 4'b0111;
    endcase
    for (int c = 0; c < 8; c++) begin
      if (c < 2) begin
        chk("an_blank", 7'(an_out), 7'h0F);
        chk("seg_blank", seg_out, 7'h7F);
      end else begin
        chk("an_show", 7'(an_out), 7'(an_exp));
        chk("seg_show", seg_out, seg);
      end
      chk("frame_done", 7'(frame_done), (d == 0 && c == 0) ? 7'(fd) : 7'h00);
      if (c == ld_off) begin
        load    = 1'b1;
        data_in = ld_val;
      end
      step();
      load = 1'b0;
    end
  endtask

  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic fd, input int ld_d, input int ld_off,
                             input logic [15:0] ld_val);
    check_slot(0, s0, fd, (ld_d == 0) ? ld_off : -1, ld_val);
    check_slot(1, s1, fd, (ld_d == 1) ? ld_off : -1, ld_val);
    check_slot(2, s2, fd, (ld_d == 2) ? ld_off : -1, ld_val);
    check_slot(3, s3, fd, (ld_d == 3) ? ld_off : -1, ld_val);
  endtask

  initial begin
    n_total     = 0;
    n_pass      = 0;
    rst         = 1'b1;
    load        = 1'b0;
    data_in     = 16'h0000;
    lz_suppress = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: "0" on every digit, no frame_done until cycle 32.
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 1'b0, -1, -1, 16'h0);
    // Load mid-frame; current frame keeps the old value.
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 1'b1, 1, 3, 16'h12AF);
    lz_suppress = 1'b1;
    check_frame(7'h0E, 7'h08, 7'h24, 7'h79, 1'b1, 1, 3, 16'h0070);
    // Leading zeros blanked with anode still low.
    check_frame(7'h40, 7'h78, 7'h7F, 7'h7F, 1'b1, 1, 3, 16'h0000);
    // All-zero value shows only digit 0; two loads before the wrap.
    check_slot(0, 7'h40, 1'b1, -1, 16'h0);
    check_slot(1, 7'h7F, 1'b1, 3, 16'h1111);
    check_slot(2, 7'h7F, 1'b1, 3, 16'h2222);
    check_slot(3, 7'h7F, 1'b1, -1, 16'h0);
    lz_suppress = 1'b0;
    check_frame(7'h24, 7'h24, 7'h24, 7'h24, 1'b1, 2, 3, 16'h4444);
    // Load on the frame_done cycle beats the pending 4444.
    check_frame(7'h30, 7'h30, 7'h30, 7'h30, 1'b1, 0, 0, 16'h3333);
    check_frame(7'h30, 7'h30, 7'h30, 7'h30, 1'b1, -1, -1, 16'h0);

    // Asynchronous reset during digit 2's SHOW.
    check_slot(0, 7'h30, 1'b1, -1, 16'h0);
    check_slot(1, 7'h30, 1'b1, -1, 16'h0);
    repeat (4) step();
    chk("an_pre_rst", 7'(an_out), 7'h0B);
    chk("seg_pre_rst", seg_out, 7'h30);
    #2 rst = 1'b1;
    #1;
    chk("an_async_rst", 7'(an_out), 7'h0F);
    chk("seg_async_rst", seg_out, 7'h7F);
    chk("fd_async_rst", 7'(frame_done), 7'h00);
    load    = 1'b1;
    data_in = 16'h5555;
    repeat (3) step();
    load = 1'b0;
    rst  = 1'b0;
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 1'b0, -1, -1, 16'h0);
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 1'b1, -1, -1, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
